boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Writer side of instruction memory. Receives a byte stream from the host link, assembles little-endian 32-bit words and writes them to instruction memory starting at byte address 0.
- Holds boot_en high for the whole load. boot_en drives the program counter, which is held at 0 while boot_en is high and fetches from 0 once it drops.
- Sits between the host byte receiver and the instruction memory write port.

Parameters:
- ADDR_W, 32, width of imem_addr (byte address).
- MAX_WORDS, 4096, largest accepted image length in words.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  single-cycle request to begin a boot load
- byte_vld  input  1  byte_data valid
- byte_data  input  8  stream byte
- byte_rdy  output  1  loader can accept a byte this cycle
- imem_we  output  1  instruction memory write strobe
- imem_addr  output  ADDR_W  byte address of the write
- imem_wdata  output  32  write data
- boot_en  output  1  load in progress; holds the CPU PC at 0
- boot_done  output  1  single-cycle pulse when the load completes
- boot_err  output  1  sticky error flag

Behaviour:
- Reset values: all outputs 0, state IDLE, internal counters 0.
- Stream format:
  - 2 length bytes, LSB first: word count N, 16 bits.
  - Then N×4 data bytes; each word is LSB first.
- Transfer rule: a byte transfers in a cycle where byte_vld & byte_rdy are both 1. byte_data is ignored otherwise.
- byte_rdy is combinational from state only: 1 in LEN0, LEN1, DATA, CHK; 0 elsewhere. It never depends on byte_vld.
- FSM:
  - IDLE: when start=1 → LEN0; clear boot_err, addr, word/byte counters.
  - LEN0: on transfer, latch N[7:0] → LEN1.
  - LEN1: on transfer, latch N[15:8], then:
    - if N==0 → CHK (macro on) or FINISH (macro off);
    - if N>MAX_WORDS → set boot_err → IDLE; no writes occur;
    - else → DATA.
  - DATA: on transfer, shift the byte into word lane [byte_cnt]. When the 4th byte transfers → WRITE.
  - WRITE: one cycle with imem_we=1, imem_addr=current addr, imem_wdata=assembled word. Then addr+=4 and word_cnt+=1. If word_cnt+1==N → CHK/FINISH, else → DATA.
  - CHK: only exists when the optional feature is compiled in (see below).
  - FINISH: boot_done=1 for one cycle → IDLE.
- Latency: the 4th byte of a word transfers in cycle T → imem_we=1 in cycle T+1. The earliest next byte transfers in T+2.
- Address: starts at 0, steps by 4. Wraps modulo 2^ADDR_W; MAX_WORDS keeps it in range in practice.
- boot_en: 1 in every state except IDLE, including FINISH. It is 0 in the cycle after the boot_done pulse.
- imem_addr and imem_wdata are don't-care when imem_we=0, but must not change between the WRITE cycle and its commit.
- start while not in IDLE is ignored.
- boot_err is held until the next accepted start.
- Reset mid-load: all outputs return to 0 immediately. A partial image is left in memory with no cleanup.

Optional Feature:
- Macro: BOOT_CHKSUM_EN.
- Defined:
  - After the last data byte (or after LEN1 when N==0), the FSM enters CHK and accepts one more byte.
  - That byte must equal the XOR of all data bytes (0x00 when N==0).
  - Mismatch sets boot_err. boot_done still pulses, then the FSM returns to IDLE.
- Undefined: CHK state and XOR register are absent. After the last WRITE (or LEN1 with N==0) the FSM goes directly to FINISH. boot_err is set only by length overflow.

Test Plan:
1. Reset, start, stream 02 00 | 13 00 00 00 | 6F 00 00 00, byte_vld held 1:
   - imem_we pulses twice: addr 0x0 data 0x00000013, then addr 0x4 data 0x0000006F.
   - boot_done pulses once; boot_en high from the cycle after start through FINISH.
2. Length overflow: with MAX_WORDS=4, stream 05 00 → boot_err=1, no imem_we, back in IDLE, boot_en=0. A following start clears boot_err.
3. Backpressure/gaps: same image as test 1, with byte_vld deasserted on random cycles and low for 3 cycles inside a word:
   - Identical writes result.
   - byte_rdy=0 in every WRITE cycle, and no byte is lost while byte_rdy=0.
4. Zero length: stream 00 00 → no writes, boot_done pulses; with BOOT_CHKSUM_EN, checksum byte 00 is accepted first.
5. BOOT_CHKSUM_EN with the test 1 image:
   - Checksum 0x7C → boot_err=0.
   - Checksum 0x7D → boot_err=1 and boot_done still pulses.
6. Assert rst_n=0 after the second data byte → byte_rdy, boot_en, imem_we drop to 0 asynchronously. After release plus start, a full image loads correctly from addr 0.

Source files
------------

// File: rtl/boot_loader.sv
// boot_loader: writer side of the instruction memory.
//
// Receives a byte stream from the host link (2 length bytes giving the word
// count N, LSB first, then N little-endian 32-bit words) and writes the words
// to instruction memory from byte address 0 upward. boot_en stays high for
// the whole load so the CPU program counter is held at 0.
//
// Optional feature: define BOOT_CHKSUM_EN to expect one extra trailing byte
// equal to the XOR of all data bytes; a mismatch sets boot_err.
//
// Parameters:
//   ADDR_W     width of imem_addr (byte address)
//   MAX_WORDS  largest accepted image length in words
//
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset
//   start       single-cycle request to begin a boot load (ignored when busy)
//   byte_vld    byte_data valid
//   byte_data   stream byte
//   byte_rdy    loader can accept a byte this cycle (depends on state only)
//   imem_we     instruction memory write strobe
//   imem_addr   byte address of the write
//   imem_wdata  write data
//   boot_en     load in progress; holds the CPU PC at 0
//   boot_done   single-cycle pulse when the load completes
//   boot_err    sticky error flag, cleared by the next accepted start

module boot_loader #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_vld,
  input  logic [7:0]        byte_data,
  output logic              byte_rdy,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              boot_en,
  output logic              boot_done,
  output logic              boot_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN0   = 3'd1,
    LEN1   = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
`ifdef BOOT_CHKSUM_EN
    CHK    = 3'd5,
`endif
    FINISH = 3'd6
  } state_e;

  // State entered once the last word is written (or straight after LEN1
  // when the image is empty).
`ifdef BOOT_CHKSUM_EN
  localparam state_e TAIL = CHK;
`else
  localparam state_e TAIL = FINISH;
`endif

  state_e            state_q, state_d;
  logic [15:0]       len_q;
  logic [15:0]       word_cnt_q;
  logic [1:0]        byte_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       word_q;
  logic              err_q;
`ifdef BOOT_CHKSUM_EN
  logic [7:0]        xor_q;
`endif

  logic        xfer;
  logic [15:0] lenFull;
  logic        lenZero;
  logic        lenOver;
  logic        lastWord;

  assign xfer     = byte_vld & byte_rdy;
  // Full length as it becomes known during the LEN1 transfer.
  assign lenFull  = {byte_data, len_q[7:0]};
  assign lenZero  = (lenFull == 16'd0);
  assign lenOver  = ({16'd0, lenFull} > 32'(MAX_WORDS));
  assign lastWord = ((word_cnt_q + 16'd1) == len_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = LEN0;
      LEN0:   if (xfer) state_d = LEN1;
      LEN1: begin
        if (xfer) begin
          if (lenZero)      state_d = TAIL;
          else if (lenOver) state_d = IDLE;
          else              state_d = DATA;
        end
      end
      DATA:   if (xfer && (byte_cnt_q == 2'd3)) state_d = WRITE;
      WRITE:  state_d = lastWord ? TAIL : DATA;
`ifdef BOOT_CHKSUM_EN
      CHK:    if (xfer) state_d = FINISH;
`endif
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state only, so byte_rdy never
  // depends on byte_vld and everything drops with the async reset.
  always_comb begin
    byte_rdy  = 1'b0;
    imem_we   = 1'b0;
    boot_done = 1'b0;
    boot_en   = (state_q != IDLE);
    case (state_q)
      LEN0, LEN1, DATA: byte_rdy = 1'b1;
`ifdef BOOT_CHKSUM_EN
      CHK:              byte_rdy = 1'b1;
`endif
      WRITE:            imem_we = 1'b1;
      FINISH:           boot_done = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr  = addr_q;
  assign imem_wdata = word_q;
  assign boot_err   = err_q;

  // Datapath: length capture, word assembly, address/word counting, error.
  // addr_q and word_q only move after the WRITE cycle, so the write bus is
  // stable for the whole strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      err_q      <= 1'b0;
`ifdef BOOT_CHKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            err_q      <= 1'b0;
            addr_q     <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
`ifdef BOOT_CHKSUM_EN
            xor_q      <= '0;
`endif
          end
        end
        LEN0: if (xfer) len_q[7:0] <= byte_data;
        LEN1: begin
          if (xfer) begin
            len_q[15:8] <= byte_data;
            if (!lenZero && lenOver) err_q <= 1'b1;
          end
        end
        DATA: begin
          if (xfer) begin
            word_q[{byte_cnt_q, 3'b000} +: 8] <= byte_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef BOOT_CHKSUM_EN
            xor_q      <= xor_q ^ byte_data;
`endif
          end
        end
        WRITE: begin
          addr_q     <= addr_q + ADDR_W'(4);
          word_cnt_q <= word_cnt_q + 16'd1;
        end
`ifdef BOOT_CHKSUM_EN
        CHK: if (xfer && (byte_data != xor_q)) err_q <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Testbench for boot_loader. Drives byte streams, pushes the expected memory
// writes into a scoreboard queue as each word is sent, and pops/compares them
// whenever the DUT strobes imem_we.
module tb_boot_loader;

  localparam int ADDR_W    = 32;
  localparam int MAX_WORDS = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              byte_vld;
  logic [7:0]        byte_data;
  logic              byte_rdy;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              boot_en;
  logic              boot_done;
  logic              boot_err;

  boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_vld   (byte_vld),
    .byte_data  (byte_data),
    .byte_rdy   (byte_rdy),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .boot_en    (boot_en),
    .boot_done  (boot_done),
    .boot_err   (boot_err)
  );

  int compared   = 0;
  int mismatched = 0;
  int doneCount  = 0;
  int expDone    = 0;

  logic [63:0] sbQ[$];
  logic [31:0] image[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write, and
  // the loader must not be accepting bytes while it writes.
  always @(negedge clk) begin
    if (boot_done) doneCount++;
    if (imem_we) begin
      checkOutput("rdyInWrite", 64'(byte_rdy), 64'd0);
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedWrite", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = sbQ.pop_front();
        checkOutput("writeAddr", 64'(imem_addr), 64'(e[63:32]));
        checkOutput("writeData", 64'(imem_wdata), 64'(e[31:0]));
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic applyStimulus(input logic [7:0] b, input int gapCycles);
    int waited;
    repeat (gapCycles) begin
      byte_vld  = 1'b0;
      byte_data = 8'($urandom);
      @(negedge clk);
    end
    byte_vld  = 1'b1;
    byte_data = b;
    waited = 0;
    while (!byte_rdy && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!byte_rdy) begin
      checkOutput("rdyTimeout", 64'd0, 64'd1);
    end else begin
      @(negedge clk);
    end
    byte_vld  = 1'b0;
    byte_data = 8'hA5;
  endtask

  task automatic startLoad();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("enAfterStart", 64'(boot_en), 64'd1);
    checkOutput("errClearedByStart", 64'(boot_err), 64'd0);
  endtask

  task automatic loadImage(input bit gapped, input bit badChk, input bit pokeStart);
    logic [7:0] x;
    logic [7:0] b;
    logic [15:0] n;
    logic expErr;
    int g;
    int w;
    n = 16'(image.size());
    x = 8'h00;
`ifdef BOOT_CHKSUM_EN
    expErr = badChk;
`else
    expErr = 1'b0;
    if (badChk) $display("[TB] checksum byte not part of this build");
`endif
    startLoad();
    applyStimulus(n[7:0], 0);
    applyStimulus(n[15:8], 0);
    for (int i = 0; i < int'(n); i++) begin
      sbQ.push_back({32'(i * 4), image[i]});
      for (int k = 0; k < 4; k++) begin
        b = image[i][8*k +: 8];
        x = x ^ b;
        if (!gapped)               g = 0;
        else if (i == 0 && k == 2) g = 3;
        else                       g = int'($urandom_range(0, 2));
        if (pokeStart && i == 1 && k == 0) start = 1'b1;
        applyStimulus(b, g);
        start = 1'b0;
      end
    end
`ifdef BOOT_CHKSUM_EN
    applyStimulus(badChk ? (x ^ 8'h01) : x, 0);
`endif
    w = 0;
    while (!boot_done && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkOutput("doneSeen", 64'(boot_done), 64'd1);
    checkOutput("enAtDone", 64'(boot_en), 64'd1);
    expDone++;
    @(negedge clk);
    checkOutput("enAfterDone", 64'(boot_en), 64'd0);
    checkOutput("errAfterLoad", 64'(boot_err), 64'(expErr));
    checkOutput("sbDrained", 64'(sbQ.size()), 64'd0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    byte_vld  = 1'b0;
    byte_data = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("rstRdy",   64'(byte_rdy),   64'd0);
    checkOutput("rstWe",    64'(imem_we),    64'd0);
    checkOutput("rstAddr",  64'(imem_addr),  64'd0);
    checkOutput("rstWdata", 64'(imem_wdata), 64'd0);
    checkOutput("rstEn",    64'(boot_en),    64'd0);
    checkOutput("rstDone",  64'(boot_done),  64'd0);
    checkOutput("rstErr",   64'(boot_err),   64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic two-word image.
    $display("[TB] basic load");
    image = '{32'h0000_0013, 32'h0000_006F};
    loadImage(1'b0, 1'b0, 1'b0);

    // Length overflow, then a maximum-length image (start poked mid-load).
    $display("[TB] length overflow");
    startLoad();
    applyStimulus(8'h05, 0);
    applyStimulus(8'h00, 0);
    checkOutput("ovfErr", 64'(boot_err), 64'd1);
    checkOutput("ovfEn",  64'(boot_en),  64'd0);
    checkOutput("ovfRdy", 64'(byte_rdy), 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("ovfErrSticky", 64'(boot_err), 64'd1);
    image = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D, 32'h0102_0304};
    loadImage(1'b0, 1'b0, 1'b1);

    // Random gaps and a 3-cycle hole inside the first word.
    $display("[TB] gapped stream");
    image = '{32'h0000_0013, 32'h0000_006F};
    loadImage(1'b1, 1'b0, 1'b0);

    // Empty image.
    $display("[TB] zero length");
    image = {};
    loadImage(1'b0, 1'b0, 1'b0);

`ifdef BOOT_CHKSUM_EN
    $display("[TB] checksum good/bad");
    image = '{32'h0000_0013, 32'h0000_006F};
    loadImage(1'b0, 1'b0, 1'b0);
    loadImage(1'b0, 1'b1, 1'b0);
`endif

    // Reset after the second data byte, then a clean reload.
    $display("[TB] reset mid-load");
    startLoad();
    applyStimulus(8'h02, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h13, 0);
    applyStimulus(8'h00, 0);
    checkOutput("rdyBeforeReset", 64'(byte_rdy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rdyInReset", 64'(byte_rdy), 64'd0);
    checkOutput("enInReset",  64'(boot_en),  64'd0);
    checkOutput("weInReset",  64'(imem_we),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    image = '{32'h0000_0013, 32'h0000_006F};
    loadImage(1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("donePulseCount", 64'(doneCount), 64'(expDone));
    checkOutput("sbEmptyAtEnd", 64'(sbQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
